// File: rtl/fe_fft_reorder_if.sv
`default_nettype none
// ============================================================================
//  Module   : fe_fft_reorder_if
//  Purpose  : Streaming bus between the last FFT butterfly stage and the
//             reorder buffer, and from the reorder buffer to the equalizer.
//             There is no backpressure, so the bus has no ready signal.
//  Signals  : i_valid  input pair valid
//             i_data   input pair, indexed [element][I=0,Q=1]
//             o_valid  output pair valid
//             o_data   output pair, indexed [element][I=0,Q=1]
//             o_sof    first pair of an output frame
//             o_eof    last pair of an output frame
//  Modports : master - upstream side, drives i_* and observes o_*
//             slave  - reorder buffer, consumes i_* and drives o_*
//  Revision : 1.0  initial release
// ============================================================================
interface fe_fft_reorder_if #(
    parameter int NBW = 9
);
    logic                            i_valid;
    logic signed [1:0][1:0][NBW-1:0] i_data;
    logic                            o_valid;
    logic signed [1:0][1:0][NBW-1:0] o_data;
    logic                            o_sof;
    logic                            o_eof;

    modport master (
        output i_valid, i_data,
        input  o_valid, o_data, o_sof, o_eof
    );

    modport slave (
        input  i_valid, i_data,
        output o_valid, o_data, o_sof, o_eof
    );
endinterface
`default_nettype wire

// File: rtl/fe_fft_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fe_fft_reorder
//  Purpose  : Output reorder buffer for the serial radix-2^2 FFT. Pairs arrive
//             in bit-reversed pair order and leave in natural order through
//             a ping-pong RAM (one bank filling while the other drains).
//  Ports    : clk          clock
//             rst_async_n  asynchronous reset, active-low
//             i_clear      synchronous clear, drops partial/pending frames
//             bus          fe_fft_reorder_if.slave (i_valid/i_data in,
//                          o_valid/o_data/o_sof/o_eof out)
//  Params   : NBW     width of each I/Q component
//             LOG2_N  log2 of FFT size N (>= 2); a frame is N/2 pairs
//  Revision : 1.0  initial release
// ============================================================================
module fe_fft_reorder #(
    parameter int NBW    = 9,
    parameter int LOG2_N = 3
) (
    input  wire logic       clk,
    input  wire logic       rst_async_n,
    input  wire logic       i_clear,
    fe_fft_reorder_if.slave bus
);

    localparam int            AW        = LOG2_N - 1;
    localparam int            HALF      = 1 << AW;
    localparam int            DW        = 4 * NBW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(HALF - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = x[AW-1-i];
        end
        return r;
    endfunction

    // Ping-pong storage, one whole pair per word. Contents are never reset;
    // the output valid gating keeps stale words from being flagged.
    logic [DW-1:0] mem [2][HALF];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_pair;
    logic          wr_bank;
    logic          wr_en;
    logic          swap;

    assign wr_en = bus.i_valid && !i_clear;
    assign swap  = wr_en && (wr_pair == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][bitrev(wr_pair)] <= bus.i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            wr_pair <= '0;
            wr_bank <= 1'b0;
        end else if (i_clear) begin
            wr_pair <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en) begin
            wr_pair <= wr_pair + 1'b1;
            if (swap) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank status: set when a bank's frame completes, cleared when its
    // last pair is read. The two events always target different banks
    // because a frame cannot complete faster than a bank drains.
    // ------------------------------------------------------------------
    logic [1:0] full;
    logic [1:0] full_set;
    logic [1:0] full_clr;
    logic       rd_last;
    logic       rd_bank;

    assign full_set = swap    ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = rd_last ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            full <= 2'b00;
        end else if (i_clear) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~full_clr) | full_set;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_next;
    logic          rd_bank_next;
    logic          rd_en;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_next;
            rd_addr <= rd_addr_next;
            rd_bank <= rd_bank_next;
        end
    end

    always_comb begin
        state_next   = state;
        rd_addr_next = rd_addr;
        rd_bank_next = rd_bank;
        rd_en        = 1'b0;
        rd_last      = 1'b0;
        if (i_clear) begin
            state_next   = IDLE;
            rd_addr_next = '0;
            rd_bank_next = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state_next   = READ;
                        rd_addr_next = '0;
                    end
                end
                READ: begin
                    rd_en = 1'b1;
                    if (rd_addr == LAST_ADDR) begin
                        rd_last      = 1'b1;
                        rd_addr_next = '0;
                        rd_bank_next = ~rd_bank;
                        // A frame already waiting in the other bank is
                        // read straight away so full-rate streams have
                        // no bubble between frames.
                        state_next   = full[~rd_bank] ? READ : IDLE;
                    end else begin
                        rd_addr_next = rd_addr + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered RAM read doubles as the output register; o_data only
    // updates on a read so it holds its value between bursts.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            bus.o_valid <= 1'b0;
            bus.o_sof   <= 1'b0;
            bus.o_eof   <= 1'b0;
            bus.o_data  <= '0;
        end else if (i_clear) begin
            bus.o_valid <= 1'b0;
            bus.o_sof   <= 1'b0;
            bus.o_eof   <= 1'b0;
            bus.o_data  <= '0;
        end else begin
            bus.o_valid <= rd_en;
            bus.o_sof   <= rd_en && (rd_addr == '0);
            bus.o_eof   <= rd_last;
            if (rd_en) begin
                bus.o_data <= mem[rd_bank][rd_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fe_fft_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fe_fft_reorder
//  Purpose  : Self-checking bench for fe_fft_reorder. Drives an N=8 and an
//             N=64 instance; expected beats come from a natural-order frame
//             model and the documented latency (first pair 2 cycles after
//             the last input pair).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fe_fft_reorder;

    localparam int NBW = 9;
    localparam int DW  = 4 * NBW;

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
        int            c;
    } beat_t;

    logic clk         = 1'b0;
    logic rst_async_n = 1'b0;
    logic clear       = 1'b0;
    int   cyc         = 0;
    int   tests       = 0;
    int   fails       = 0;

    int    xi [64];
    int    xq [64];
    beat_t got8  [$];
    beat_t exp8  [$];
    beat_t got64 [$];
    beat_t exp64 [$];

    fe_fft_reorder_if #(.NBW(NBW)) bus8 ();
    fe_fft_reorder_if #(.NBW(NBW)) bus64 ();

    fe_fft_reorder #(.NBW(NBW), .LOG2_N(3)) dut8 (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .i_clear    (clear),
        .bus        (bus8.slave)
    );

    fe_fft_reorder #(.NBW(NBW), .LOG2_N(6)) dut64 (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .i_clear    (clear),
        .bus        (bus64.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus8.o_valid === 1'b1)
            got8.push_back('{bus8.o_data, bus8.o_sof, bus8.o_eof, cyc});
        if (bus64.o_valid === 1'b1)
            got64.push_back('{bus64.o_data, bus64.o_sof, bus64.o_eof, cyc});
    end

    // ---------------- model / stimulus helpers (no checking) ----------------
    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    function automatic logic [DW-1:0] pack(input int i0, input int q0, input int i1, input int q1);
        logic [1:0][1:0][NBW-1:0] v;
        v[0][0] = NBW'(i0);
        v[0][1] = NBW'(q0);
        v[1][0] = NBW'(i1);
        v[1][1] = NBW'(q1);
        return v;
    endfunction

    function automatic int rnd9();
        return int'($urandom_range(511, 0)) - 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [DW-1:0] d);
        bus8.i_valid = 1'b1;
        bus8.i_data  = d;
        tick();
        bus8.i_valid = 1'b0;
    endtask

    task automatic send64(input logic [DW-1:0] d);
        bus64.i_valid = 1'b1;
        bus64.i_data  = d;
        tick();
        bus64.i_valid = 1'b0;
    endtask

    // Sends the frame held in xi/xq (N=8) in bit-reversed order with `gap`
    // idle cycles between pairs, then records the natural-order beats.
    task automatic send_frame8(input int gap);
        int t;
        for (int p = 0; p < 4; p++) begin
            int k = brev(p, 2);
            send8(pack(xi[k], xq[k], xi[k+4], xq[k+4]));
            if (p < 3) repeat (gap) tick();
        end
        t = cyc;
        for (int q = 0; q < 4; q++)
            exp8.push_back('{pack(xi[q], xq[q], xi[q+4], xq[q+4]), q == 0, q == 3, t + 2 + q});
    endtask

    task automatic rand_frame8();
        for (int k = 0; k < 8; k++) begin
            xi[k] = rnd9();
            xq[k] = rnd9();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests++; if (bus8.o_valid !== 1'b0) begin fails++; $display("FAIL reset o_valid: got %b required 0", bus8.o_valid); end
        tests++; if (bus8.o_sof !== 1'b0) begin fails++; $display("FAIL reset o_sof: got %b required 0", bus8.o_sof); end
        tests++; if (bus8.o_eof !== 1'b0) begin fails++; $display("FAIL reset o_eof: got %b required 0", bus8.o_eof); end
        tests++; if (bus8.o_data !== '0) begin fails++; $display("FAIL reset o_data: got %h required 0", bus8.o_data); end
        tests++; if (bus64.o_valid !== 1'b0) begin fails++; $display("FAIL reset64 o_valid: got %b required 0", bus64.o_valid); end
        tests++; if (bus64.o_data !== '0) begin fails++; $display("FAIL reset64 o_data: got %h required 0", bus64.o_data); end
    endtask

    task automatic test_basic();
        got8.delete(); exp8.delete();
        for (int k = 0; k < 8; k++) begin
            xi[k] = k;
            xq[k] = -k;
        end
        send_frame8(0);
        repeat (8) tick();
        tests++;
        if (got8.size() != exp8.size()) begin fails++; $display("FAIL basic count: got %0d required %0d", got8.size(), exp8.size()); end
        for (int i = 0; i < exp8.size() && i < got8.size(); i++) begin
            tests++;
            if (got8[i].d !== exp8[i].d || got8[i].sof !== exp8[i].sof || got8[i].eof !== exp8[i].eof || got8[i].c !== exp8[i].c) begin
                fails++;
                $display("FAIL basic beat %0d: got d=%h sof=%b eof=%b cyc=%0d required d=%h sof=%b eof=%b cyc=%0d",
                         i, got8[i].d, got8[i].sof, got8[i].eof, got8[i].c, exp8[i].d, exp8[i].sof, exp8[i].eof, exp8[i].c);
            end
        end
    endtask

    task automatic test_gapped();
        got8.delete(); exp8.delete();
        for (int f = 0; f < 3; f++) begin
            rand_frame8();
            send_frame8(2);
            repeat (2) tick();
        end
        repeat (8) tick();
        tests++;
        if (got8.size() != exp8.size()) begin fails++; $display("FAIL gapped count: got %0d required %0d", got8.size(), exp8.size()); end
        for (int i = 0; i < exp8.size() && i < got8.size(); i++) begin
            tests++;
            if (got8[i].d !== exp8[i].d || got8[i].sof !== exp8[i].sof || got8[i].eof !== exp8[i].eof || got8[i].c !== exp8[i].c) begin
                fails++;
                $display("FAIL gapped beat %0d: got d=%h sof=%b eof=%b cyc=%0d required d=%h sof=%b eof=%b cyc=%0d",
                         i, got8[i].d, got8[i].sof, got8[i].eof, got8[i].c, exp8[i].d, exp8[i].sof, exp8[i].eof, exp8[i].c);
            end
        end
    endtask

    task automatic test_back_to_back_full_scale();
        got8.delete(); exp8.delete();
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 8; k++) begin
                xi[k] = ($urandom_range(1, 0) == 1) ? 255 : -255;
                xq[k] = ($urandom_range(1, 0) == 1) ? 255 : -255;
            end
            send_frame8(0);
        end
        repeat (8) tick();
        tests++;
        if (got8.size() != 20) begin fails++; $display("FAIL b2b count: got %0d required 20", got8.size()); end
        for (int i = 0; i < exp8.size() && i < got8.size(); i++) begin
            tests++;
            if (got8[i].d !== exp8[i].d || got8[i].sof !== exp8[i].sof || got8[i].eof !== exp8[i].eof || got8[i].c !== exp8[0].c + i) begin
                fails++;
                $display("FAIL b2b beat %0d: got d=%h sof=%b eof=%b cyc=%0d required d=%h sof=%b eof=%b cyc=%0d",
                         i, got8[i].d, got8[i].sof, got8[i].eof, got8[i].c, exp8[i].d, exp8[i].sof, exp8[i].eof, exp8[0].c + i);
            end
        end
    endtask

    task automatic test_clear();
        got8.delete(); exp8.delete();
        // partial frame, then clear with a simultaneous (ignored) i_valid
        rand_frame8();
        send8(pack(xi[0], xq[0], xi[4], xq[4]));
        send8(pack(xi[2], xq[2], xi[6], xq[6]));
        clear = 1'b1;
        bus8.i_valid = 1'b1;
        bus8.i_data  = pack(1, 2, 3, 4);
        tick();
        clear = 1'b0;
        bus8.i_valid = 1'b0;
        // full frame; clear during its read burst after two pairs
        rand_frame8();
        send_frame8(0);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++; if (bus8.o_valid !== 1'b0) begin fails++; $display("FAIL clear o_valid: got %b required 0", bus8.o_valid); end
        tests++; if (bus8.o_data !== '0) begin fails++; $display("FAIL clear o_data: got %h required 0", bus8.o_data); end
        void'(exp8.pop_back());
        void'(exp8.pop_back());
        repeat (8) tick();
        tests++; if (got8.size() != 2) begin fails++; $display("FAIL clear stop: got %0d beats required 2", got8.size()); end
        rand_frame8();
        send_frame8(0);
        repeat (8) tick();
        tests++;
        if (got8.size() != exp8.size()) begin fails++; $display("FAIL clear count: got %0d required %0d", got8.size(), exp8.size()); end
        for (int i = 0; i < exp8.size() && i < got8.size(); i++) begin
            tests++;
            if (got8[i].d !== exp8[i].d || got8[i].sof !== exp8[i].sof || got8[i].eof !== exp8[i].eof || got8[i].c !== exp8[i].c) begin
                fails++;
                $display("FAIL clear beat %0d: got d=%h sof=%b eof=%b cyc=%0d required d=%h sof=%b eof=%b cyc=%0d",
                         i, got8[i].d, got8[i].sof, got8[i].eof, got8[i].c, exp8[i].d, exp8[i].sof, exp8[i].eof, exp8[i].c);
            end
        end
    endtask

    task automatic test_async_reset();
        got8.delete(); exp8.delete();
        rand_frame8();
        send_frame8(0);
        repeat (3) tick();
        #2;
        rst_async_n = 1'b0;
        #1;
        tests++; if (bus8.o_valid !== 1'b0) begin fails++; $display("FAIL areset o_valid: got %b required 0", bus8.o_valid); end
        tests++; if (bus8.o_sof !== 1'b0) begin fails++; $display("FAIL areset o_sof: got %b required 0", bus8.o_sof); end
        tests++; if (bus8.o_eof !== 1'b0) begin fails++; $display("FAIL areset o_eof: got %b required 0", bus8.o_eof); end
        tests++; if (bus8.o_data !== '0) begin fails++; $display("FAIL areset o_data: got %h required 0", bus8.o_data); end
        #2;
        rst_async_n = 1'b1;
        tick();
        while (exp8.size() > 1) void'(exp8.pop_back());
        rand_frame8();
        send_frame8(0);
        repeat (8) tick();
        tests++;
        if (got8.size() != exp8.size()) begin fails++; $display("FAIL areset count: got %0d required %0d", got8.size(), exp8.size()); end
        for (int i = 0; i < exp8.size() && i < got8.size(); i++) begin
            tests++;
            if (got8[i].d !== exp8[i].d || got8[i].sof !== exp8[i].sof || got8[i].eof !== exp8[i].eof || got8[i].c !== exp8[i].c) begin
                fails++;
                $display("FAIL areset beat %0d: got d=%h sof=%b eof=%b cyc=%0d required d=%h sof=%b eof=%b cyc=%0d",
                         i, got8[i].d, got8[i].sof, got8[i].eof, got8[i].c, exp8[i].d, exp8[i].sof, exp8[i].eof, exp8[i].c);
            end
        end
    endtask

    task automatic test_random64();
        int t;
        got64.delete(); exp64.delete();
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < 64; k++) begin
                xi[k] = rnd9();
                xq[k] = rnd9();
            end
            for (int p = 0; p < 32; p++) begin
                int k = brev(p, 5);
                while ($urandom_range(9, 0) < 3) tick();
                send64(pack(xi[k], xq[k], xi[k+32], xq[k+32]));
            end
            t = cyc;
            for (int q = 0; q < 32; q++)
                exp64.push_back('{pack(xi[q], xq[q], xi[q+32], xq[q+32]), q == 0, q == 31, t + 2 + q});
        end
        repeat (40) tick();
        tests++;
        if (got64.size() != exp64.size()) begin fails++; $display("FAIL rand64 count: got %0d required %0d", got64.size(), exp64.size()); end
        for (int i = 0; i < exp64.size() && i < got64.size(); i++) begin
            tests++;
            if (got64[i].d !== exp64[i].d || got64[i].sof !== exp64[i].sof || got64[i].eof !== exp64[i].eof || got64[i].c !== exp64[i].c) begin
                fails++;
                $display("FAIL rand64 beat %0d: got d=%h sof=%b eof=%b cyc=%0d required d=%h sof=%b eof=%b cyc=%0d",
                         i, got64[i].d, got64[i].sof, got64[i].eof, got64[i].c, exp64[i].d, exp64[i].sof, exp64[i].eof, exp64[i].c);
            end
        end
    endtask

    initial begin
        bus8.i_valid  = 1'b0;
        bus8.i_data   = '0;
        bus64.i_valid = 1'b0;
        bus64.i_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #2;
        rst_async_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back_full_scale();
        test_clear();
        test_async_reset();
        test_random64();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
